// File: rtl/trigger_link_rx.sv
// Receive side of the fixed-latency trigger fiber: frames the two-word-per-BX
// 8b/10b stream, tracks lock, checks the latency marker and counts bad frames.
module trigger_link_rx #(
    parameter int LOCK_FRAMES   = 8,
    parameter int UNLOCK_ERRS   = 4,
    parameter int MARKER_PERIOD = 128,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                 usrclk2,
    input  logic                 reset,
    input  logic [31:0]          rx_data,
    input  logic [3:0]           rx_charisk,
    input  logic [3:0]           rx_codeerr,
    output logic [13:0]          cluster0,
    output logic [13:0]          cluster1,
    output logic [13:0]          cluster2,
    output logic [13:0]          cluster3,
    output logic                 overflow,
    output logic                 valid,
    output logic                 marker,
    output logic                 locked,
    output logic                 marker_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);
    localparam int XW = $clog2(MARKER_PERIOD);

    localparam logic [7:0] K_NORM     = 8'hBC;
    localparam logic [7:0] K_NORM_OVF = 8'hF7;
    localparam logic [7:0] K_MARK     = 8'hFC;
    localparam logic [7:0] K_MARK_OVF = 8'hFB;

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    // First half of the frame, held until the second word completes it
    typedef struct packed {
        logic        ok;
        logic        ovf;
        logic        mark;
        logic [23:0] data;
    } w0_t;

    state_t        state, state_nxt;
    logic          phase;
    w0_t           w0_q;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic [XW-1:0] bx_cnt;
    logic          aligned;

    logic [7:0] kbyte;
    logic       k_known, k_ovf, k_mark, w0_good, w1_good;
    logic       frame_end, frame_good, frame_bad, bx_last, mark_err_nxt;

    assign kbyte  = rx_data[7:0];
    assign locked = (state == LOCKED);

    always_comb begin
        k_ovf   = (kbyte == K_NORM_OVF) || (kbyte == K_MARK_OVF);
        k_mark  = (kbyte == K_MARK) || (kbyte == K_MARK_OVF);
        k_known = k_ovf || k_mark || (kbyte == K_NORM);
        w0_good = (rx_charisk == 4'b0001) && k_known && (rx_codeerr == 4'b0000);
        w1_good = (rx_charisk == 4'b0000) && (rx_codeerr == 4'b0000);
    end

    always_comb begin
        state_nxt    = state;
        frame_end    = (state != HUNT) && phase;
        frame_good   = frame_end && w0_q.ok && w1_good;
        frame_bad    = frame_end && !frame_good;
        bx_last      = (bx_cnt == XW'(MARKER_PERIOD - 1));
        // Until the first marker is seen the BX counter has no reference
        mark_err_nxt = (state == LOCKED) && frame_good && aligned && (w0_q.mark != bx_last);
        case (state)
            HUNT:    if (w0_good) state_nxt = SYNC;
            SYNC: begin
                if (frame_bad)
                    state_nxt = HUNT;
                else if (frame_good && (good_cnt == GW'(LOCK_FRAMES - 1)))
                    state_nxt = LOCKED;
            end
            LOCKED:  if (frame_bad && (bad_cnt == BW'(UNLOCK_ERRS - 1))) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge usrclk2) begin
        if (reset) begin
            state      <= HUNT;
            phase      <= 1'b0;
            w0_q       <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            bx_cnt     <= '0;
            aligned    <= 1'b0;
            cluster0   <= '0;
            cluster1   <= '0;
            cluster2   <= '0;
            cluster3   <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
            marker     <= 1'b0;
            marker_err <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            valid      <= 1'b0;
            marker     <= 1'b0;
            marker_err <= 1'b0;

            // In HUNT a valid W0 pins the phase; afterwards it free-runs
            if ((state == HUNT) && w0_good) phase <= 1'b1;
            else                            phase <= !phase;

            if (((state == HUNT) && w0_good) || ((state != HUNT) && !phase))
                w0_q <= '{ok: w0_good, ovf: k_ovf, mark: k_mark, data: rx_data[31:8]};

            if (state == HUNT)
                good_cnt <= '0;
            else if ((state == SYNC) && frame_good)
                good_cnt <= good_cnt + GW'(1);

            if (state != LOCKED) begin
                bad_cnt <= '0;
                bx_cnt  <= '0;
                aligned <= 1'b0;
            end else if (frame_end) begin
                if (frame_bad) begin
                    // Bad frames still occupy a BX slot but never touch the marker logic
                    bad_cnt <= bad_cnt + BW'(1);
                    bx_cnt  <= bx_cnt + XW'(1);
                    if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
                end else begin
                    bad_cnt    <= '0;
                    {cluster3, cluster2, cluster1, cluster0} <= {rx_data, w0_q.data};
                    overflow   <= w0_q.ovf;
                    valid      <= 1'b1;
                    marker     <= w0_q.mark;
                    marker_err <= mark_err_nxt;
                    if (w0_q.mark) begin
                        bx_cnt  <= '0;
                        aligned <= 1'b1;
                    end else begin
                        bx_cnt <= bx_cnt + XW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_trigger_link_rx.sv
// Bench for trigger_link_rx: frame table plus marker/error/reset sequences,
// output words checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_trigger_link_rx;

    localparam logic [7:0] K_NRM  = 8'hBC;
    localparam logic [7:0] K_OVF  = 8'hF7;
    localparam logic [7:0] K_MRK  = 8'hFC;
    localparam logic [7:0] K_MRKO = 8'hFB;

    logic        usrclk2 = 1'b0;
    logic        reset;
    logic [31:0] rx_data;
    logic [3:0]  rx_charisk;
    logic [3:0]  rx_codeerr;
    logic [13:0] cluster0, cluster1, cluster2, cluster3;
    logic        overflow, valid, marker, locked, marker_err;
    logic [15:0] err_cnt;

    trigger_link_rx dut (
        .usrclk2    (usrclk2),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_charisk (rx_charisk),
        .rx_codeerr (rx_codeerr),
        .cluster0   (cluster0),
        .cluster1   (cluster1),
        .cluster2   (cluster2),
        .cluster3   (cluster3),
        .overflow   (overflow),
        .valid      (valid),
        .marker     (marker),
        .locked     (locked),
        .marker_err (marker_err),
        .err_cnt    (err_cnt)
    );

    always #6 usrclk2 = ~usrclk2;

    typedef struct {
        logic [55:0] d;
        logic [7:0]  k;
        logic [3:0]  e0;
        logic [3:0]  e1;
        logic        ev;
        logic        eovf;
        logic        emark;
        logic        emerr;
    } vec_t;

    typedef struct {
        logic [13:0] c0, c1, c2, c3;
        logic        ovf;
        logic        mark;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   pend = 1'b0;
    logic pend_v, pend_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [55:0] d, input logic [7:0] k,
                                input logic [3:0] e0, input logic [3:0] e1,
                                input logic ev, input logic eovf,
                                input logic emark, input logic emerr);
        vec_t v;
        v.d = d; v.k = k; v.e0 = e0; v.e1 = e1;
        v.ev = ev; v.eovf = eovf; v.emark = emark; v.emerr = emerr;
        return v;
    endfunction

    task automatic send_frame(input vec_t v);
        exp_t e;
        @(negedge usrclk2);
        rx_data    = {v.d[23:0], v.k};
        rx_charisk = 4'b0001;
        rx_codeerr = v.e0;
        @(negedge usrclk2);
        rx_data    = v.d[55:24];
        rx_charisk = 4'b0000;
        rx_codeerr = v.e1;
        if (v.ev) begin
            e.c0 = v.d[13:0];  e.c1 = v.d[27:14];
            e.c2 = v.d[41:28]; e.c3 = v.d[55:42];
            e.ovf = v.eovf;    e.mark = v.emark;
            sb.push_back(e);
        end
        pend_v = v.ev;
        pend_m = v.emerr;
        pend   = 1'b1;
    endtask

    task automatic run_plain(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0]  k;
            logic [55:0] d;
            k = ($urandom_range(0, 1) == 1) ? K_OVF : K_NRM;
            d = 56'({$urandom(), $urandom()});
            send_frame(mk(d, k, 4'h0, 4'h0, 1'b1, (k == K_OVF), 1'b0, 1'b0));
        end
    endtask

    task automatic settle();
        @(posedge usrclk2);
        #2;
    endtask

    // Output-side checker: strobes in the slot after each W1, data via scoreboard
    initial begin
        forever begin
            @(posedge usrclk2);
            #1;
            if (pend) begin
                chk("valid", 32'(valid), 32'(pend_v));
                chk("marker_err", 32'(marker_err), 32'(pend_m));
                pend = 1'b0;
            end else if (valid || marker_err) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_strobe: got valid=%0b marker_err=%0b, expected 0 (t=%0t)",
                         valid, marker_err, $time);
            end
            if (valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got valid=1, expected no output (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("cluster0", 32'(cluster0), 32'(e.c0));
                    chk("cluster1", 32'(cluster1), 32'(e.c1));
                    chk("cluster2", 32'(cluster2), 32'(e.c2));
                    chk("cluster3", 32'(cluster3), 32'(e.c3));
                    chk("overflow", 32'(overflow), 32'(e.ovf));
                    chk("marker",   32'(marker),   32'(e.mark));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    localparam logic [55:0] D0 = 56'h0123456789ABCD;
    localparam logic [55:0] D2 = 56'h2468ACE0135797;
    localparam logic [55:0] D3 = 56'h13579BDF02468A;

    vec_t tbl[13];

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = mk(D0, K_NRM, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(D0,                K_NRM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(56'hFEDCBA98765432, K_OVF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(56'hFFFFFFFFFFFFFF, K_NRM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(56'h00000000000000, K_OVF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[12] = mk(56'h3FFF0000FFFFC0, K_MRK, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);

        reset      = 1'b1;
        rx_data    = '0;
        rx_charisk = '0;
        rx_codeerr = '0;
        repeat (3) @(negedge usrclk2);
        chk("rst_valid",   32'(valid),    32'd0);
        chk("rst_locked",  32'(locked),   32'd0);
        chk("rst_err_cnt", 32'(err_cnt),  32'd0);
        chk("rst_cluster", 32'(cluster0), 32'd0);
        reset = 1'b0;

        // Lock-up plus first locked frames; the last entry is the first marker
        for (int i = 0; i < 13; i++) begin
            send_frame(tbl[i]);
            if (i == 6) begin settle(); chk("locked_after_7", 32'(locked), 32'd0); end
            if (i == 7) begin settle(); chk("locked_after_8", 32'(locked), 32'd1); end
        end

        // Markers every 128 frames, then a misplaced and a missing marker
        run_plain(127);
        send_frame(mk(56'h155555AAAAAAAA, K_MRKO, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0));
        run_plain(127);
        send_frame(mk(56'h0F0F0F0F0F0F0F, K_MRK, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0));
        run_plain(100);
        send_frame(mk(56'h11111111111111, K_MRK, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1));
        run_plain(127);
        send_frame(mk(56'h22222222222222, K_MRK, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0));
        run_plain(127);
        send_frame(mk(56'h33333333333333, K_NRM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1));
        run_plain(127);
        send_frame(mk(56'h44444444444444, K_MRK, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0));

        // Error counting and loss of lock
        for (int i = 0; i < 3; i++)
            send_frame(mk(D0, K_NRM, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame(mk(D2, K_NRM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        settle();
        chk("locked_after_3bad", 32'(locked),  32'd1);
        chk("err_cnt_3",         32'(err_cnt), 32'd3);
        send_frame(mk(D0, K_MRK, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame(mk(D0, 8'h3C, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame(mk(D0, K_NRM, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0));
        settle();
        chk("locked_bad_3of4", 32'(locked),   32'd1);
        chk("hold_cluster0",   32'(cluster0), 32'(D2[13:0]));
        send_frame(mk(D0, K_NRM, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        settle();
        chk("unlocked_4bad", 32'(locked),  32'd0);
        chk("err_cnt_7",     32'(err_cnt), 32'd7);

        // Odd-phase entry: a lone W1 must not start a frame
        @(negedge usrclk2);
        reset = 1'b1;
        rx_data = '0; rx_charisk = '0; rx_codeerr = '0;
        repeat (2) @(negedge usrclk2);
        reset = 1'b0;
        chk("rst2_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge usrclk2);
        rx_data = 32'h12345678; rx_charisk = 4'b0000; rx_codeerr = 4'h0;
        for (int i = 0; i < 7; i++)
            send_frame(mk(D3, K_NRM, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        settle();
        chk("odd_locked_7", 32'(locked), 32'd0);
        send_frame(mk(D3, K_NRM, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        settle();
        chk("odd_locked_8", 32'(locked), 32'd1);
        send_frame(mk(D3, K_OVF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0));
        settle();

        // Reset arriving with the second word of a frame
        @(negedge usrclk2);
        rx_data = {D0[23:0], K_NRM}; rx_charisk = 4'b0001; rx_codeerr = 4'h0;
        @(negedge usrclk2);
        reset = 1'b1;
        rx_data = D0[55:24]; rx_charisk = 4'b0000;
        settle();
        chk("midrst_valid",    32'(valid),      32'd0);
        chk("midrst_locked",   32'(locked),     32'd0);
        chk("midrst_cluster0", 32'(cluster0),   32'd0);
        chk("midrst_cluster3", 32'(cluster3),   32'd0);
        chk("midrst_overflow", 32'(overflow),   32'd0);
        chk("midrst_merr",     32'(marker_err), 32'd0);
        @(negedge usrclk2);
        reset = 1'b0;
        send_frame(mk(D0, K_NRM, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        settle();
        chk("post_rst_hunt", 32'(locked), 32'd0);

        repeat (2) @(negedge usrclk2);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
